hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Upstream controller for the EX-stage ForwardMux pair: produces the 2-bit operand selects
//  for each mux, detects load-use hazards and inserts bubbles, and flushes on taken branches.
//  Tracks destination registers of in-flight instructions in shadow slots EX, MEM and WB,
//  advanced in lockstep with the datapath pipeline registers.
// PARAMETERS
//  REG_ADDR_W  5   register-index width (32 architectural regs, x0 hard-wired zero)
//  CNT_W       16  width of stall/bubble performance counter
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           asynchronous, active-high reset
//  id_rs1         in   REG_ADDR_W  source reg 1 of instruction in ID
//  id_rs2         in   REG_ADDR_W  source reg 2 of instruction in ID
//  id_uses_rs1    in   1           ID instr reads rs1
//  id_uses_rs2    in   1           ID instr reads rs2
//  id_rd          in   REG_ADDR_W  destination reg of ID instr
//  id_reg_write   in   1           ID instr writes rd
//  id_mem_read    in   1           ID instr is a load
//  branch_taken   in   1           branch resolved taken in EX this cycle
//  ext_stall      in   1           memory wait; freezes whole pipeline
//  fwd_a_sel      out  2           select for operand-A ForwardMux
//  fwd_b_sel      out  2           select for operand-B ForwardMux
//  pc_write_en    out  1           0 = hold PC
//  if_id_write_en out  1           0 = hold IF/ID register
//  id_ex_bubble   out  1           1 = load NOP into ID/EX register
//  if_id_flush    out  1           1 = clear IF/ID register
//  stall_cnt      out  CNT_W       saturating count of cycles with bubble inserted
// BEHAVIOUR
//  - Reset: all slots invalid (rd=0, reg_write=0, mem_read=0); stall_cnt=0; fwd_*_sel=2'b00;
//    pc_write_en=if_id_write_en=1; id_ex_bubble=if_id_flush=0. Reset mid-operation drops all slots.
//  - Select encoding: 2'b00 regfile (a), 2'b01 WB result (b), 2'b10 MEM/ALU result (c); 2'b11 never driven.
//  - fwd_a_sel (b analogous with rs2): combinational from slot registers, zero added latency:
//    MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rs1 -> 2'b10; else WB.reg_write & WB.rd!=0 &
//    WB.rd==EX.rs1 -> 2'b01; else 2'b00. MEM wins over WB. x0 never forwarded.
//  - Load-use: EX.mem_read & EX.rd!=0 & ((id_uses_rs1 & EX.rd==id_rs1)|(id_uses_rs2 & EX.rd==id_rs2))
//    -> pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 for exactly one cycle; the load then
//    reaches MEM and the held instr is satisfied via WB forwarding (2'b01) one cycle later.
//  - Flush: branch_taken -> if_id_flush=1, id_ex_bubble=1; pc_write_en stays 1. Flush wins over
//    load-use in the same cycle (stalled instr is on the wrong path).
//  - ext_stall (highest priority): pc_write_en=if_id_write_en=0, id_ex_bubble=if_id_flush=0,
//    no slot advances, selects hold. Upstream keeps branch_taken asserted until ext_stall drops.
//  - Slot advance each non-frozen cycle: WB<=MEM, MEM<=EX, EX<=ID fields, or all-zero when id_ex_bubble.
//  - stall_cnt += 1 on every id_ex_bubble cycle; saturates at all-ones, no wrap.
// STRUCTURE
//  - Package hazard_pkg: fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10};
//    slot_t struct {rd, rs1, rs2, reg_write, mem_read}; SLOT_NOP constant.
//  - One sub-module hazard_slot_reg: slot_t register with async reset, enable and bubble-load.
//  - Forward compare and hazard priority logic kept in this module.
// TESTING
//  1 add x5,..; add x6,x5,x1 back-to-back -> next cycle fwd_a_sel=2'b10, no stall.
//  2 add x5; nop; sub x7,x2,x5 -> fwd_b_sel=2'b01 when sub is in EX.
//  3 lw x8; add x9,x8,x8 -> 1 cycle pc_write_en=0, id_ex_bubble=1, then fwd_a_sel=fwd_b_sel=2'b01; stall_cnt=1.
//  4 add x0,..; add x3,x0,x0 -> selects stay 2'b00; lw x0 then use x0 -> no stall.
//  5 lw x4 + dependent use with branch_taken=1 same cycle -> if_id_flush=1, pc_write_en=1, one bubble.
//  6 ext_stall=1 for 3 cycles mid-sequence -> selects/slots frozen; rst pulse mid-run -> all outputs to reset values.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the EX-stage hazard/forwarding controller: mux selects, shadow slots, compare helper.
// Slots mirror only the register-index fields the hazard logic needs, not the datapath payload.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             reg_write;
        logic             mem_read;
    } slot_t;

    localparam slot_t SLOT_NOP = '0;

    // MEM is the younger producer, so it must win over WB; x0 is never a real producer.
    function automatic fwd_sel_t fwd_select(
        input logic             mem_wr,
        input logic [REG_W-1:0] mem_rd,
        input logic             wb_wr,
        input logic [REG_W-1:0] wb_rd,
        input logic [REG_W-1:0] src
    );
        if (mem_wr && (mem_rd != '0) && (mem_rd == src)) begin
            return FWD_MEM;
        end
        if (wb_wr && (wb_rd != '0) && (wb_rd == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// One shadow pipeline slot: holds when en=0, loads d or a NOP (bubble) when en=1.
// Asynchronous active-high reset empties the slot.
module hazard_slot_reg
    import hazard_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SLOT_NOP;
        end else if (en) begin
            q <= bubble ? SLOT_NOP : d;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forward-select, load-use stall and branch-flush control for the EX-stage operand muxes.
// Selects are combinational from the shadow slots; control outputs are combinational from ID inputs and slots.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    input  logic                  ext_stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic [CNT_W-1:0]      stall_cnt
);

    slot_t id_slot;
    slot_t ex_q;
    slot_t mem_q;
    slot_t wb_q;
    logic  advance;
    logic  load_use;

    assign id_slot = '{rd:        id_rd,
                       rs1:       id_rs1,
                       rs2:       id_rs2,
                       reg_write: id_reg_write,
                       mem_read:  id_mem_read};

    assign advance = ~ext_stall;

    hazard_slot_reg u_ex_slot (
        .clk    (clk),
        .rst    (rst),
        .en     (advance),
        .bubble (id_ex_bubble),
        .d      (id_slot),
        .q      (ex_q)
    );

    hazard_slot_reg u_mem_slot (
        .clk    (clk),
        .rst    (rst),
        .en     (advance),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    hazard_slot_reg u_wb_slot (
        .clk    (clk),
        .rst    (rst),
        .en     (advance),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    assign fwd_a_sel = fwd_select(mem_q.reg_write, mem_q.rd, wb_q.reg_write, wb_q.rd, ex_q.rs1);
    assign fwd_b_sel = fwd_select(mem_q.reg_write, mem_q.rd, wb_q.reg_write, wb_q.rd, ex_q.rs2);

    assign load_use = ex_q.mem_read && (ex_q.rd != '0) &&
                      ((id_uses_rs1 && (ex_q.rd == id_rs1)) ||
                       (id_uses_rs2 && (ex_q.rd == id_rs2)));

    // A taken branch outranks load-use: the stalled instruction is on the wrong path anyway.
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_bubble   = 1'b0;
        if_id_flush    = 1'b0;
        if (ext_stall) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_ex_bubble && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    logic unused_slot_bits;
    assign unused_slot_bits = ^{mem_q.rs1, mem_q.rs2, mem_q.mem_read,
                                wb_q.rs1, wb_q.rs2, wb_q.mem_read};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: per-cycle vector table for forwarding/stall/flush/freeze, plus a mid-run reset sequence.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic        branch_taken, ext_stall;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        pc_write_en, if_id_write_en, id_ex_bubble, if_id_flush;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .branch_taken   (branch_taken),
        .ext_stall      (ext_stall),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs1, rs2, u1, u2, rd, rw, mr, br, es;
        int ea, eb, epc, eifid, ebub, efl, ecnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int rs1, input int rs2, input int u1, input int u2,
                         input int rd, input int rw, input int mr, input int br, input int es);
        id_rs1       = 5'(rs1);
        id_rs2       = 5'(rs2);
        id_uses_rs1  = 1'(u1);
        id_uses_rs2  = 1'(u2);
        id_rd        = 5'(rd);
        id_reg_write = 1'(rw);
        id_mem_read  = 1'(mr);
        branch_taken = 1'(br);
        ext_stall    = 1'(es);
    endtask

    task automatic chk_all(input string tag, input int a, input int b, input int pc,
                           input int ifid, input int bub, input int fl, input int cnt);
        chk({tag, ".fwd_a_sel"},      32'(fwd_a_sel),      32'(a));
        chk({tag, ".fwd_b_sel"},      32'(fwd_b_sel),      32'(b));
        chk({tag, ".pc_write_en"},    32'(pc_write_en),    32'(pc));
        chk({tag, ".if_id_write_en"}, 32'(if_id_write_en), 32'(ifid));
        chk({tag, ".id_ex_bubble"},   32'(id_ex_bubble),   32'(bub));
        chk({tag, ".if_id_flush"},    32'(if_id_flush),    32'(fl));
        chk({tag, ".stall_cnt"},      32'(stall_cnt),      32'(cnt));
    endtask

    initial begin
        // Each row is one cycle: ID inputs, then the outputs expected before that cycle's edge.
        //            rs1 rs2 u1 u2 rd rw mr br es   a  b pc ifid bub fl cnt
        // add x5 ; add x6,x5,x1 -> MEM forward on A
        vq.push_back('{ 1,  2, 1, 1,  5, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0});
        vq.push_back('{ 5,  1, 1, 1,  6, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 0,  2, 0, 1, 1, 0, 0, 0});
        // add x5 ; nop ; sub x7,x2,x5 -> WB forward on B
        vq.push_back('{ 1,  2, 1, 1,  5, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0});
        vq.push_back('{ 2,  5, 1, 1,  7, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0, 0});
        // lw x8 ; add x9,x8,x8 -> one stall, then WB forward on both
        vq.push_back('{ 1,  0, 1, 0,  8, 1, 1, 0, 0,  0, 0, 1, 1, 0, 0, 0});
        vq.push_back('{ 8,  8, 1, 1,  9, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0});
        vq.push_back('{ 8,  8, 1, 1,  9, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0, 1});
        // add x0 ; add x3,x0,x0 ; lw x0 ; use x0 -> nothing forwarded, no stall
        vq.push_back('{ 1,  2, 1, 1,  0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1});
        vq.push_back('{ 0,  0, 1, 1,  3, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1});
        vq.push_back('{ 1,  0, 1, 0,  0, 1, 1, 0, 0,  0, 0, 1, 1, 0, 0, 1});
        vq.push_back('{ 0,  0, 1, 1, 10, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1});
        // lw x4 ; dependent use with branch taken -> flush wins, PC keeps moving
        vq.push_back('{ 1,  0, 1, 0,  4, 1, 1, 0, 0,  0, 0, 1, 1, 0, 0, 1});
        vq.push_back('{ 4,  1, 1, 1, 11, 1, 0, 1, 0,  0, 0, 1, 1, 1, 1, 1});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 2});
        // add x12 ; add x13,x12,x12 ; ext_stall x3 (with a held branch) -> frozen
        vq.push_back('{ 1,  2, 1, 1, 12, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 2});
        vq.push_back('{12, 12, 1, 1, 13, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 2});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 1,  2, 2, 0, 0, 0, 0, 2});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 1, 1,  2, 2, 0, 0, 0, 0, 2});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 1,  2, 2, 0, 0, 0, 0, 2});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 0,  2, 2, 1, 1, 0, 0, 2});
        vq.push_back('{ 0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 2});

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_all("reset", 0, 0, 1, 1, 0, 0, 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            drive(vq[i].rs1, vq[i].rs2, vq[i].u1, vq[i].u2, vq[i].rd,
                  vq[i].rw, vq[i].mr, vq[i].br, vq[i].es);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), vq[i].ea, vq[i].eb, vq[i].epc,
                    vq[i].eifid, vq[i].ebub, vq[i].efl, vq[i].ecnt);
            @(posedge clk);
            #1;
        end

        // Mid-run reset while a MEM forward and a load-use stall are both live.
        drive(1, 2, 1, 1, 5, 1, 0, 0, 0);
        @(posedge clk); #1;
        drive(5, 0, 1, 0, 8, 1, 1, 0, 0);
        @(posedge clk); #1;
        drive(8, 8, 1, 1, 9, 1, 0, 0, 0);
        @(negedge clk);
        chk_all("pre_rst", 2, 0, 0, 0, 1, 0, 2);
        rst = 1'b1;
        #1;
        chk_all("in_rst", 0, 0, 1, 1, 0, 0, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("post_rst", 0, 0, 1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
